wrr_quantum_sched: RTL

WRR_QUANTUM_SCHED -- requirements
Module: wrr_quantum_sched

---
 rtl/wrr_quantum_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wrr_quantum_sched.sv
// Four-requester weighted round-robin arbiter: each owner holds the grant for up
// to its own quantum of cycles, then hands over to the next requester in rr order.

module wrr_qslot #(
  parameter int QW              = 8,
  parameter int DEFAULT_QUANTUM = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [QW-1:0] wdata,
  output logic [QW-1:0] load_val
);
  logic [QW-1:0] q;

  always_ff @(posedge clk or posedge rst)
    if (rst)     q <= QW'(DEFAULT_QUANTUM);
    else if (we) q <= wdata;

  // A quantum of 0 behaves as 1, so both load a counter of 0.
  assign load_val = (q == '0) ? '0 : q - 1'b1;
endmodule

module wrr_quantum_sched #(
  parameter int QW              = 8,
  parameter int DEFAULT_QUANTUM = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          req2,
  input  logic          req3,
  input  logic          cfg_we,
  input  logic [1:0]    cfg_sel,
  input  logic [QW-1:0] cfg_quantum,
  output logic          gnt0,
  output logic          gnt1,
  output logic          gnt2,
  output logic          gnt3,
  output logic          gnt_valid,
  output logic [1:0]    gnt_id,
  output logic [QW-1:0] quantum_left,
  output logic          preempt
);
  localparam int NUM_REQ = 4;
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [NUM_REQ-1:0]         req_v;
  logic [NUM_REQ-1:0][QW-1:0] load_val;

  logic [0:0]         state, nxt_state;
  logic [1:0]         owner, nxt_owner;
  logic [1:0]         ptr, nxt_ptr;
  logic [QW-1:0]      cnt, nxt_cnt;
  logic               nxt_pre;
  logic [NUM_REQ-1:0] gnt_r;
  logic               pre_r;

  logic [1:0] owner_inc;
  logic [1:0] srch_start;
  logic       srch_found;
  logic [1:0] srch_idx;

  assign req_v     = {req3, req2, req1, req0};
  assign owner_inc = owner + 2'd1;

  genvar g;
  generate
    for (g = 0; g < NUM_REQ; g++) begin : g_slot
      wrr_qslot #(.QW(QW), .DEFAULT_QUANTUM(DEFAULT_QUANTUM)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .we       (cfg_we && (cfg_sel == 2'(g))),
        .wdata    (cfg_quantum),
        .load_val (load_val[g])
      );
    end
  endgenerate

  // Any handover searches from owner+1; idle arbitration searches from the pointer.
  assign srch_start = (state == ST_IDLE) ? ptr : owner_inc;

  always_comb begin
    srch_found = 1'b0;
    srch_idx   = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!srch_found && req_v[srch_start + 2'(k)]) begin
        srch_found = 1'b1;
        srch_idx   = srch_start + 2'(k);
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_ptr   = ptr;
    nxt_cnt   = cnt;
    nxt_pre   = 1'b0;
    if (state == ST_IDLE) begin
      if (srch_found) begin
        nxt_state = ST_GRANT;
        nxt_owner = srch_idx;
        nxt_cnt   = load_val[srch_idx];
      end
    end else if (!req_v[owner]) begin
      nxt_ptr = owner_inc;
      if (srch_found) begin
        nxt_owner = srch_idx;
        nxt_cnt   = load_val[srch_idx];
      end else begin
        nxt_state = ST_IDLE;
        nxt_owner = 2'd0;
        nxt_cnt   = '0;
      end
    end else if (cnt == '0) begin
      // Owner still requesting, so the search wraps back to it when nobody else is.
      nxt_ptr   = owner_inc;
      nxt_owner = srch_idx;
      nxt_cnt   = load_val[srch_idx];
      nxt_pre   = (srch_idx != owner);
    end else begin
      nxt_cnt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      owner <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= '0;
      gnt_r <= '0;
      pre_r <= 1'b0;
    end else begin
      state <= nxt_state;
      owner <= nxt_owner;
      ptr   <= nxt_ptr;
      cnt   <= nxt_cnt;
      gnt_r <= (nxt_state == ST_GRANT) ? (NUM_REQ'(1) << nxt_owner) : '0;
      pre_r <= nxt_pre;
    end
  end

  assign gnt0         = gnt_r[0];
  assign gnt1         = gnt_r[1];
  assign gnt2         = gnt_r[2];
  assign gnt3         = gnt_r[3];
  assign gnt_valid    = state;
  assign gnt_id       = owner;
  assign quantum_left = cnt;
  assign preempt      = pre_r;
endmodule
